// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave over a word-addressed SRAM with independent read and write FSMs,
// each carrying one outstanding transaction with a programmable response latency.
module axi4_lite_sram_slave #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 64,
   parameter int unsigned           DEPTH_LOG2 = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80000000,
   parameter int unsigned           RD_LAT     = 2,
   parameter int unsigned           WR_LAT     = 2
) (
   input  logic                    iClock,
   input  logic                    iResetN,
   input  logic                    pAXI4_ar_valid,
   input  logic [ADDR_WIDTH-1:0]   pAXI4_ar_bits_addr,
   output logic                    pAXI4_ar_ready,
   output logic                    pAXI4_r_valid,
   output logic [DATA_WIDTH-1:0]   pAXI4_r_bits_data,
   output logic [1:0]              pAXI4_r_bits_resp,
   input  logic                    pAXI4_r_ready,
   input  logic                    pAXI4_aw_valid,
   input  logic [ADDR_WIDTH-1:0]   pAXI4_aw_bits_addr,
   output logic                    pAXI4_aw_ready,
   input  logic                    pAXI4_w_valid,
   input  logic [DATA_WIDTH-1:0]   pAXI4_w_bits_data,
   input  logic [DATA_WIDTH/8-1:0] pAXI4_w_bits_strb,
   output logic                    pAXI4_w_ready,
   output logic                    pAXI4_b_valid,
   output logic [1:0]              pAXI4_b_bits_resp,
   input  logic                    pAXI4_b_ready
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W  = 16;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rstate_e;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wstate_e;

   // Offset wraps modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR land out of range.
   function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] off;
      off = addr - BASE_ADDR;
      return (off >> (OFF_W + DEPTH_LOG2)) == '0;
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] off;
      off = addr - BASE_ADDR;
      return DEPTH_LOG2'(off >> OFF_W);
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   rstate_e               rstate_q, rstate_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [CNT_W-1:0]      rcnt_q, rcnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   wstate_e               wstate_q, wstate_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic                  aw_got_q, aw_got_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  w_got_q, w_got_d;
   logic [CNT_W-1:0]      wcnt_q, wcnt_d;
   logic [1:0]            bresp_q, bresp_d;

   logic                  ar_hs_s, aw_hs_s, w_hs_s, rd_load_s, commit_s;
   logic                  awready_s, wready_s;
   logic [ADDR_WIDTH-1:0] raddr_eff_s, awaddr_eff_s;
   logic [DATA_WIDTH-1:0] wdata_eff_s;
   logic [STRB_W-1:0]     wstrb_eff_s;

   assign awready_s    = (wstate_q == W_IDLE) && !aw_got_q;
   assign wready_s     = (wstate_q == W_IDLE) && !w_got_q;
   assign ar_hs_s      = pAXI4_ar_valid && (rstate_q == R_IDLE);
   assign aw_hs_s      = pAXI4_aw_valid && awready_s;
   assign w_hs_s       = pAXI4_w_valid && wready_s;
   // With zero latency the response is formed from the beats arriving this cycle.
   assign raddr_eff_s  = (rstate_q == R_IDLE) ? pAXI4_ar_bits_addr : raddr_q;
   assign awaddr_eff_s = aw_got_q ? awaddr_q : pAXI4_aw_bits_addr;
   assign wdata_eff_s  = w_got_q ? wdata_q : pAXI4_w_bits_data;
   assign wstrb_eff_s  = w_got_q ? wstrb_q : pAXI4_w_bits_strb;

   // State register for both channel FSMs and their latched beats.
   always_ff @(posedge iClock or negedge iResetN) begin
      if (!iResetN) begin
         rstate_q <= R_IDLE;
         raddr_q  <= '0;
         rcnt_q   <= '0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         wstate_q <= W_IDLE;
         awaddr_q <= '0;
         aw_got_q <= 1'b0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         w_got_q  <= 1'b0;
         wcnt_q   <= '0;
         bresp_q  <= RESP_OKAY;
      end else begin
         rstate_q <= rstate_d;
         raddr_q  <= raddr_d;
         rcnt_q   <= rcnt_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         wstate_q <= wstate_d;
         awaddr_q <= awaddr_d;
         aw_got_q <= aw_got_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         w_got_q  <= w_got_d;
         wcnt_q   <= wcnt_d;
         bresp_q  <= bresp_d;
      end
   end

   // Read next-state: latency countdown, then sample the array on entry to R_RESP.
   always_comb begin
      rstate_d  = rstate_q;
      raddr_d   = raddr_q;
      rcnt_d    = rcnt_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rd_load_s = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            if (ar_hs_s) begin
               raddr_d = pAXI4_ar_bits_addr;
               if (RD_LAT == 0) begin
                  rstate_d  = R_RESP;
                  rd_load_s = 1'b1;
               end else begin
                  rstate_d = R_WAIT;
                  rcnt_d   = CNT_W'(RD_LAT);
               end
            end else begin
               rstate_d = R_IDLE;
            end
         end
         R_WAIT: begin
            if (rcnt_q <= CNT_W'(1)) begin
               rstate_d  = R_RESP;
               rd_load_s = 1'b1;
            end else begin
               rcnt_d = rcnt_q - CNT_W'(1);
            end
         end
         R_RESP: begin
            if (pAXI4_r_ready) begin
               rstate_d = R_IDLE;
            end else begin
               rstate_d = R_RESP;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
      if (rd_load_s) begin
         if (addr_in_range(raddr_eff_s)) begin
            rdata_d = mem_q[word_idx(raddr_eff_s)];
            rresp_d = RESP_OKAY;
         end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Write next-state: gather AW and W in any order, count down, commit on entry to W_RESP.
   always_comb begin
      wstate_d = wstate_q;
      awaddr_d = awaddr_q;
      aw_got_d = aw_got_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      w_got_d  = w_got_q;
      wcnt_d   = wcnt_q;
      bresp_d  = bresp_q;
      commit_s = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (aw_hs_s) begin
               awaddr_d = pAXI4_aw_bits_addr;
               aw_got_d = 1'b1;
            end else begin
               aw_got_d = aw_got_q;
            end
            if (w_hs_s) begin
               wdata_d = pAXI4_w_bits_data;
               wstrb_d = pAXI4_w_bits_strb;
               w_got_d = 1'b1;
            end else begin
               w_got_d = w_got_q;
            end
            if ((aw_got_q || aw_hs_s) && (w_got_q || w_hs_s)) begin
               if (WR_LAT == 0) begin
                  wstate_d = W_RESP;
                  commit_s = 1'b1;
               end else begin
                  wstate_d = W_WAIT;
                  wcnt_d   = CNT_W'(WR_LAT);
               end
            end else begin
               wstate_d = W_IDLE;
            end
         end
         W_WAIT: begin
            if (wcnt_q <= CNT_W'(1)) begin
               wstate_d = W_RESP;
               commit_s = 1'b1;
            end else begin
               wcnt_d = wcnt_q - CNT_W'(1);
            end
         end
         W_RESP: begin
            if (pAXI4_b_ready) begin
               wstate_d = W_IDLE;
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
            end else begin
               wstate_d = W_RESP;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
      if (commit_s) begin
         bresp_d = addr_in_range(awaddr_eff_s) ? RESP_OKAY : RESP_SLVERR;
      end else begin
         bresp_d = bresp_q;
      end
   end

   // Array byte-lane writes; contents survive reset, and a held reset blocks any commit.
   always_ff @(posedge iClock) begin
      if (iResetN && commit_s && addr_in_range(awaddr_eff_s)) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb_eff_s[i]) begin
               mem_q[word_idx(awaddr_eff_s)][8*i +: 8] <= wdata_eff_s[8*i +: 8];
            end
         end
      end
   end

   // Channel outputs decoded from registered state.
   always_comb begin
      pAXI4_ar_ready    = (rstate_q == R_IDLE);
      pAXI4_r_valid     = (rstate_q == R_RESP);
      pAXI4_r_bits_data = rdata_q;
      pAXI4_r_bits_resp = rresp_q;
      pAXI4_aw_ready    = awready_s;
      pAXI4_w_ready     = wready_s;
      pAXI4_b_valid     = (wstate_q == W_RESP);
      pAXI4_b_bits_resp = bresp_q;
   end

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Bench for axi4_lite_sram_slave: instance 0 uses RD_LAT=WR_LAT=2, instance 1 uses zero latency.
module tb_axi4_lite_sram_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ar_valid [2];
   logic [31:0] ar_addr  [2];
   logic        ar_ready [2];
   logic        r_valid  [2];
   logic [63:0] r_data   [2];
   logic [1:0]  r_resp   [2];
   logic        r_ready  [2];
   logic        aw_valid [2];
   logic [31:0] aw_addr  [2];
   logic        aw_ready [2];
   logic        w_valid  [2];
   logic [63:0] w_data   [2];
   logic [7:0]  w_strb   [2];
   logic        w_ready  [2];
   logic        b_valid  [2];
   logic [1:0]  b_resp   [2];
   logic        b_ready  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi4_lite_sram_slave #(.RD_LAT(2), .WR_LAT(2)) u_dut0 (
      .iClock(clk), .iResetN(rst_n),
      .pAXI4_ar_valid(ar_valid[0]), .pAXI4_ar_bits_addr(ar_addr[0]), .pAXI4_ar_ready(ar_ready[0]),
      .pAXI4_r_valid(r_valid[0]), .pAXI4_r_bits_data(r_data[0]), .pAXI4_r_bits_resp(r_resp[0]),
      .pAXI4_r_ready(r_ready[0]),
      .pAXI4_aw_valid(aw_valid[0]), .pAXI4_aw_bits_addr(aw_addr[0]), .pAXI4_aw_ready(aw_ready[0]),
      .pAXI4_w_valid(w_valid[0]), .pAXI4_w_bits_data(w_data[0]), .pAXI4_w_bits_strb(w_strb[0]),
      .pAXI4_w_ready(w_ready[0]),
      .pAXI4_b_valid(b_valid[0]), .pAXI4_b_bits_resp(b_resp[0]), .pAXI4_b_ready(b_ready[0])
   );

   axi4_lite_sram_slave #(.RD_LAT(0), .WR_LAT(0)) u_dut1 (
      .iClock(clk), .iResetN(rst_n),
      .pAXI4_ar_valid(ar_valid[1]), .pAXI4_ar_bits_addr(ar_addr[1]), .pAXI4_ar_ready(ar_ready[1]),
      .pAXI4_r_valid(r_valid[1]), .pAXI4_r_bits_data(r_data[1]), .pAXI4_r_bits_resp(r_resp[1]),
      .pAXI4_r_ready(r_ready[1]),
      .pAXI4_aw_valid(aw_valid[1]), .pAXI4_aw_bits_addr(aw_addr[1]), .pAXI4_aw_ready(aw_ready[1]),
      .pAXI4_w_valid(w_valid[1]), .pAXI4_w_bits_data(w_data[1]), .pAXI4_w_bits_strb(w_strb[1]),
      .pAXI4_w_ready(w_ready[1]),
      .pAXI4_b_valid(b_valid[1]), .pAXI4_b_bits_resp(b_resp[1]), .pAXI4_b_ready(b_ready[1])
   );

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      string       name;
   } exp_t;

   typedef struct {
      bit          is_wr;
      int          d;
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      int          mode;
      logic [63:0] exp_data;
      logic [1:0]  exp_resp;
      string       name;
   } vec_t;

   exp_t rq[$];
   exp_t bq[$];
   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic void add_vec(input bit is_wr, input int d, input logic [31:0] addr,
                                   input logic [63:0] data, input logic [7:0] strb, input int mode,
                                   input logic [63:0] exp_data, input logic [1:0] exp_resp,
                                   input string name);
      vec_t v;
      v.is_wr = is_wr; v.d = d; v.addr = addr; v.data = data; v.strb = strb; v.mode = mode;
      v.exp_data = exp_data; v.exp_resp = exp_resp; v.name = name;
      vecs.push_back(v);
   endfunction

   task automatic chk_reset_state(input string nm);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_arready"}, 64'(ar_ready[d]), 64'd1);
         chk({nm, "_awready"}, 64'(aw_ready[d]), 64'd1);
         chk({nm, "_wready"},  64'(w_ready[d]),  64'd1);
         chk({nm, "_rvalid"},  64'(r_valid[d]),  64'd0);
         chk({nm, "_bvalid"},  64'(b_valid[d]),  64'd0);
         chk({nm, "_rdata"},   r_data[d],        64'd0);
         chk({nm, "_rresp"},   64'(r_resp[d]),   64'd0);
         chk({nm, "_bresp"},   64'(b_resp[d]),   64'd0);
      end
   endtask

   task automatic do_read(input int d, input logic [31:0] addr, input logic [63:0] ed,
                          input logic [1:0] er, input string nm);
      exp_t e;
      int   n;
      int   lat;
      e.data = ed; e.resp = er; e.name = nm;
      rq.push_back(e);
      ar_addr[d]  = addr;
      ar_valid[d] = 1'b1;
      n = 0;
      while (!ar_ready[d] && n < 50) begin tick(); n++; end
      tick();
      ar_valid[d] = 1'b0;
      lat = 0;
      while (!r_valid[d] && lat < 50) begin tick(); lat++; end
      e = rq.pop_front();
      chk({e.name, "_rvalid"}, 64'(r_valid[d]), 64'd1);
      chk({e.name, "_rdata"},  r_data[d],       e.data);
      chk({e.name, "_rresp"},  64'(r_resp[d]),  64'(e.resp));
      chk({e.name, "_rlat"},   64'(lat),        (d == 0) ? 64'd2 : 64'd0);
      r_ready[d] = 1'b1;
      tick();
      r_ready[d] = 1'b0;
      chk({e.name, "_rdrop"},  64'(r_valid[d]), 64'd0);
   endtask

   // mode 0: AW and W together; 1: AW one cycle ahead of W; 2: W one cycle ahead of AW
   task automatic do_write(input int d, input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input int mode, input logic [1:0] er,
                           input string nm);
      exp_t e;
      bit   aw_done, w_done, aw_hs, w_hs;
      int   cyc;
      int   lat;
      e.data = 64'd0; e.resp = er; e.name = nm;
      bq.push_back(e);
      aw_addr[d] = addr; w_data[d] = data; w_strb[d] = strb;
      aw_done = 1'b0; w_done = 1'b0; cyc = 0;
      while (!(aw_done && w_done) && cyc < 50) begin
         aw_valid[d] = !aw_done && (cyc >= ((mode == 2) ? 1 : 0));
         w_valid[d]  = !w_done  && (cyc >= ((mode == 1) ? 1 : 0));
         aw_hs = aw_valid[d] && aw_ready[d];
         w_hs  = w_valid[d] && w_ready[d];
         tick();
         if (aw_hs) aw_done = 1'b1;
         if (w_hs)  w_done  = 1'b1;
         cyc++;
      end
      aw_valid[d] = 1'b0;
      w_valid[d]  = 1'b0;
      lat = 0;
      while (!b_valid[d] && lat < 50) begin tick(); lat++; end
      e = bq.pop_front();
      chk({e.name, "_bvalid"}, 64'(b_valid[d]), 64'd1);
      chk({e.name, "_bresp"},  64'(b_resp[d]),  64'(e.resp));
      chk({e.name, "_blat"},   64'(lat),        (d == 0) ? 64'd2 : 64'd0);
      b_ready[d] = 1'b1;
      tick();
      b_ready[d] = 1'b0;
      chk({e.name, "_readyback"}, 64'({aw_ready[d], w_ready[d], b_valid[d]}), 64'b110);
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         ar_valid[d] = 1'b0; ar_addr[d] = 32'd0; r_ready[d] = 1'b0;
         aw_valid[d] = 1'b0; aw_addr[d] = 32'd0; w_valid[d] = 1'b0;
         w_data[d] = 64'd0; w_strb[d] = 8'd0; b_ready[d] = 1'b0;
      end

      //        wr  d  addr            data                   strb   mode exp_data               resp
      add_vec(1'b1, 0, 32'h80000008, 64'h1122334455667788, 8'hFF, 0, 64'd0,                 2'b00, "pre8");
      add_vec(1'b0, 0, 32'h80000008, 64'd0,                8'h00, 0, 64'h1122334455667788, 2'b00, "t1_read");
      add_vec(1'b1, 0, 32'h80000000, 64'h0123456789ABCDEF, 8'hFF, 2, 64'd0,                 2'b00, "pre0");
      add_vec(1'b1, 0, 32'h80000000, 64'hAABBCCDD00000000, 8'hF0, 1, 64'd0,                 2'b00, "t2_hiwr");
      add_vec(1'b0, 0, 32'h80000000, 64'd0,                8'h00, 0, 64'hAABBCCDD89ABCDEF, 2'b00, "t2_read");
      add_vec(1'b1, 0, 32'h80000004, 64'h0000000000000055, 8'h01, 0, 64'd0,                 2'b00, "lowbits_wr");
      add_vec(1'b0, 0, 32'h80000007, 64'd0,                8'h00, 0, 64'hAABBCCDD89ABCD55, 2'b00, "lowbits_rd");
      add_vec(1'b1, 0, 32'h80000000, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, 64'd0,                 2'b00, "strb0_wr");
      add_vec(1'b0, 0, 32'h80000000, 64'd0,                8'h00, 0, 64'hAABBCCDD89ABCD55, 2'b00, "strb0_rd");
      add_vec(1'b0, 0, 32'h7FFFFFF8, 64'd0,                8'h00, 0, 64'd0,                 2'b10, "t3_rd_oor");
      add_vec(1'b1, 0, 32'h80008000, 64'hDEADBEEFDEADBEEF, 8'hFF, 0, 64'd0,                 2'b10, "t3_wr_oor");
      add_vec(1'b0, 0, 32'h80000000, 64'd0,                8'h00, 0, 64'hAABBCCDD89ABCD55, 2'b00, "t3_noalias");
      add_vec(1'b1, 0, 32'h80007FF8, 64'hCAFEF00D12345678, 8'hFF, 1, 64'd0,                 2'b00, "last_wr");
      add_vec(1'b0, 0, 32'h80007FF8, 64'd0,                8'h00, 0, 64'hCAFEF00D12345678, 2'b00, "last_rd");
      add_vec(1'b0, 0, 32'h80008000, 64'd0,                8'h00, 0, 64'd0,                 2'b10, "oor_rd2");
      add_vec(1'b1, 1, 32'h80000020, 64'h0123456789ABCDEF, 8'hFF, 2, 64'd0,                 2'b00, "d1_wr");
      add_vec(1'b1, 1, 32'h80000020, 64'h00000000FFFFFFFF, 8'h0F, 1, 64'd0,                 2'b00, "d1_lo");
      add_vec(1'b0, 1, 32'h80000020, 64'd0,                8'h00, 0, 64'h01234567FFFFFFFF, 2'b00, "d1_rd");

      #12;
      chk_reset_state("reset");
      tick();
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         if (vecs[i].is_wr)
            do_write(vecs[i].d, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].mode,
                     vecs[i].exp_resp, vecs[i].name);
         else
            do_read(vecs[i].d, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, vecs[i].name);
      end

      // Read stalled by rready low: response held, new AR refused.
      do_write(0, 32'h80000010, 64'h0F1E2D3C4B5A6978, 8'hFF, 0, 2'b00, "stall_pre");
      e.data = 64'h0F1E2D3C4B5A6978; e.resp = 2'b00; e.name = "stall";
      rq.push_back(e);
      ar_addr[0] = 32'h80000010; ar_valid[0] = 1'b1;
      tick();
      ar_addr[0] = 32'h80000008;
      for (int n = 0; n < 50 && !r_valid[0]; n++) tick();
      e = rq.pop_front();
      for (int c = 0; c < 5; c++) begin
         chk("stall_rvalid",  64'(r_valid[0]),  64'd1);
         chk("stall_rdata",   r_data[0],        e.data);
         chk("stall_rresp",   64'(r_resp[0]),   64'(e.resp));
         chk("stall_arready", 64'(ar_ready[0]), 64'd0);
         tick();
      end
      r_ready[0] = 1'b1;
      tick();
      r_ready[0] = 1'b0; ar_valid[0] = 1'b0;
      chk("stall_release", 64'({r_valid[0], ar_ready[0]}), 64'b01);

      // Zero latency: same-edge AR/AW/W to one word reads pre-write data.
      do_write(1, 32'h80000010, 64'h1111111111111111, 8'hFF, 0, 2'b00, "t5_pre");
      e.data = 64'h1111111111111111; e.resp = 2'b00; e.name = "t5_old";
      rq.push_back(e);
      ar_addr[1] = 32'h80000010; aw_addr[1] = 32'h80000010;
      w_data[1] = 64'h2222222222222222; w_strb[1] = 8'hFF;
      ar_valid[1] = 1'b1; aw_valid[1] = 1'b1; w_valid[1] = 1'b1;
      tick();
      ar_valid[1] = 1'b0; aw_valid[1] = 1'b0; w_valid[1] = 1'b0;
      e = rq.pop_front();
      chk("t5_rvalid", 64'(r_valid[1]), 64'd1);
      chk("t5_rdata",  r_data[1],       e.data);
      chk("t5_bvalid", 64'(b_valid[1]), 64'd1);
      chk("t5_bresp",  64'(b_resp[1]),  64'd0);
      r_ready[1] = 1'b1; b_ready[1] = 1'b1;
      tick();
      r_ready[1] = 1'b0; b_ready[1] = 1'b0;
      do_read(1, 32'h80000010, 64'h2222222222222222, 2'b00, "t5_new");

      // Async reset while a write waits out its latency: write is abandoned.
      do_write(0, 32'h80000018, 64'h5555555555555555, 8'hFF, 0, 2'b00, "t6_pre");
      aw_addr[0] = 32'h80000018; w_data[0] = 64'h6666666666666666; w_strb[0] = 8'hFF;
      aw_valid[0] = 1'b1; w_valid[0] = 1'b1;
      tick();
      aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_reset_state("t6_reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_still_idle", 64'(b_valid[0]), 64'd0);
      do_read(0, 32'h80000018, 64'h5555555555555555, 2'b00, "t6_unchanged");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
